// File: rtl/keypad_emu.sv
// Keypad emulator: drives active-low column lines back to a row-scanning keypad
// controller so that one key appears pressed for a set number of scan frames.
module keypad_emu #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sel,
  input  logic             start,
  input  logic [3:0]       key,
  input  logic [CNT_W-1:0] hold_scans,
  input  logic [CNT_W-1:0] gap_scans,
  output logic [2:0]       column,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    PRESS,
    RELEASE,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] gap_q;
  logic [3:0]       key_q;
  logic [2:0]       prev_sel;
  logic [2:0]       key_row;
  logic [2:0]       key_col;
  logic [CNT_W-1:0] hold_eff;
  logic             frame_tick;

  // A frame starts when the scanner wraps from its last row back to row 0;
  // sel 6-7 can never take part in this pattern.
  assign frame_tick = (prev_sel == 3'd5) && (sel == 3'd0);
  assign hold_eff   = (hold_scans == '0) ? CNT_W'(1) : hold_scans;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    key_row = 3'd7;
    key_col = 3'b111;
    case (key_q)
      4'd0: begin key_row = 3'd3; key_col = 3'b101; end
      4'd1: begin key_row = 3'd0; key_col = 3'b011; end
      4'd2: begin key_row = 3'd0; key_col = 3'b101; end
      4'd3: begin key_row = 3'd0; key_col = 3'b110; end
      4'd4: begin key_row = 3'd1; key_col = 3'b011; end
      4'd5: begin key_row = 3'd1; key_col = 3'b101; end
      4'd6: begin key_row = 3'd1; key_col = 3'b110; end
      4'd7: begin key_row = 3'd2; key_col = 3'b011; end
      4'd8: begin key_row = 3'd2; key_col = 3'b101; end
      4'd9: begin key_row = 3'd2; key_col = 3'b110; end
      default: ;
    endcase
    column = 3'b111;
    if (state == PRESS && sel == key_row) column = key_col;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_q   <= '0;
      gap_q    <= '0;
      key_q    <= 4'hF;
      prev_sel <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev_sel <= sel;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (key <= 4'd9) begin
              key_q  <= key;
              hold_q <= hold_eff;
              gap_q  <= gap_scans;
              busy   <= 1'b1;
              state  <= ALIGN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ALIGN: begin
          if (frame_tick) begin
            cnt   <= hold_q;
            state <= PRESS;
          end
        end
        PRESS: begin
          if (frame_tick) begin
            // The state changes at the end of the row-0 cycle, so row 0 is
            // covered by the same number of frames as rows 1-3.
            if (cnt <= CNT_W'(1)) begin
              if (gap_q == '0) begin
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                cnt   <= gap_q;
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (frame_tick) begin
            if (cnt <= CNT_W'(1)) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emu.sv
// Scoreboard bench for keypad_emu: stimulus pushes expected press records,
// a monitor decodes the column lines and checks each done/err event.
module tb_keypad_emu;

  localparam int CNT_W  = 4;
  localparam int BUDGET = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       sel;
  logic             start;
  logic [3:0]       key;
  logic [CNT_W-1:0] hold_scans;
  logic [CNT_W-1:0] gap_scans;
  logic [2:0]       column;
  logic             busy;
  logic             done;
  logic             err;

  keypad_emu #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .start      (start),
    .key        (key),
    .hold_scans (hold_scans),
    .gap_scans  (gap_scans),
    .column     (column),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef enum logic { EV_DONE, EV_ERR } ev_t;
  typedef struct {
    ev_t        kind;
    logic [3:0] key;
    int         actives;
    int         ticks;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   err_seen = 0;
  logic [15:0] buffer = '0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic logic [3:0] decode(input logic [2:0] s, input logic [2:0] c);
    int ci;
    case (c)
      3'b011:  ci = 0;
      3'b101:  ci = 1;
      3'b110:  ci = 2;
      default: return 4'hF;
    endcase
    if (s <= 3'd2) return 4'(int'(s) * 3 + ci + 1);
    if (s == 3'd3 && ci == 1) return 4'd0;
    return 4'hF;
  endfunction

  // Scanner model: one row per clock, cycling 0-5.
  initial begin
    sel = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      sel = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
    end
  end

  // Monitor: samples on the falling edge, mid-cycle.
  initial begin
    logic [2:0] prev_s;
    logic [3:0] seen_key;
    logic       key_bad;
    int         actives;
    int         ticks;
    exp_t       e;
    prev_s = 3'd0; seen_key = 4'hF; key_bad = 1'b0; actives = 0; ticks = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        actives = 0; ticks = 0; seen_key = 4'hF; key_bad = 1'b0;
      end else begin
        if (prev_s == 3'd5 && sel == 3'd0 && busy) ticks++;
        if (column != 3'b111) begin
          if (actives == 0) seen_key = decode(sel, column);
          else if (decode(sel, column) != seen_key) key_bad = 1'b1;
          actives++;
        end
        if (err) begin
          err_seen++;
          check("err_busy", int'(busy), 0);
          check("err_column", int'(column), 7);
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL err_unexpected: got err pulse, want none");
          end else begin
            e = sb.pop_front();
            check("err_kind", int'(EV_ERR), int'(e.kind));
          end
        end
        if (done) begin
          done_seen++;
          check("done_busy", int'(busy), 0);
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_unexpected: got done pulse, want none");
          end else begin
            e = sb.pop_front();
            check("done_kind", int'(e.kind), int'(EV_DONE));
            check("done_key", key_bad ? 15 : int'(seen_key), int'(e.key));
            check("done_actives", actives, e.actives);
            check("done_ticks", ticks, e.ticks);
          end
          buffer = {buffer[11:0], seen_key};
          actives = 0; ticks = 0; seen_key = 4'hF; key_bad = 1'b0;
        end
      end
      prev_s = sel;
    end
  end

  task automatic press(input logic [3:0] k, input int h, input int g);
    exp_t e;
    int   he;
    he = (h == 0) ? 1 : h;
    e.kind    = (k <= 4'd9) ? EV_DONE : EV_ERR;
    e.key     = k;
    e.actives = he;
    e.ticks   = 1 + he + g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b1; key = k; hold_scans = CNT_W'(h); gap_scans = CNT_W'(g);
    @(posedge clk);
    #1;
    start = 1'b0; key = 4'd8; hold_scans = '1; gap_scans = '1;
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = BUDGET;
    while (done_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_seen < target) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_done: got %0d done pulses, want %0d", done_seen, target);
    end
  endtask

  task automatic wait_active();
    int budget;
    budget = BUDGET;
    do begin
      @(negedge clk);
      budget--;
    end while (column == 3'b111 && budget > 0);
    if (column == 3'b111) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_active: got column 111, want a pressed key");
    end
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; key = 4'd0; hold_scans = '0; gap_scans = '0;
    #12;
    check("rst_column", int'(column), 7);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // key 5, hold 2, gap 1
    press(4'd5, 2, 1);
    wait_done(1);

    // key 0, hold 0 treated as 1, gap 0
    press(4'd0, 0, 0);
    wait_done(2);

    // invalid key
    press(4'hB, 1, 1);
    budget = BUDGET;
    while (err_seen < 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("err_count", err_seen, 1);

    // second start while pressing is ignored
    press(4'd6, 2, 0);
    wait_active();
    @(posedge clk);
    #1;
    start = 1'b1; key = 4'd9; hold_scans = CNT_W'(1); gap_scans = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3);
    repeat (30) @(posedge clk);
    check("no_extra_done", done_seen, 3);

    // reset in the middle of a press aborts it
    press(4'd5, 3, 1);
    wait_active();
    #1;
    reset = 1'b1;
    #1;
    check("abort_column", int'(column), 7);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    press(4'd7, 1, 1);
    wait_done(4);

    // keys 1, 2, 3 in sequence
    press(4'd1, 3, 2);
    wait_done(5);
    press(4'd2, 3, 2);
    wait_done(6);
    press(4'd3, 3, 2);
    wait_done(7);
    check("buffer_123", int'(buffer[11:0]), 'h123);

    repeat (20) @(posedge clk);
    check("final_done_count", done_seen, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter: CNT_W, default 4, width of the hold_scans and gap_scans frame counters.
REQ-002 clk  input  1  system clock; same clock that advances the scanner's row select.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 sel  input  3  row select driven by the keypad scanner; valid rows 0-5, one value per clk.
REQ-005 start  input  1  single-cycle request to emulate one key press.
REQ-006 key  input  4  key to press, 0-9 binary; sampled when start is accepted.
REQ-007 hold_scans  input  CNT_W  number of full scan frames the key is held down; 0 is treated as 1.
REQ-008 gap_scans  input  CNT_W  number of full released frames after the key is let go; 0 is allowed.
REQ-009 column  output  3  active-low column lines returned to the scanner; 3'b111 means no key.
REQ-010 busy  output  1  high from the cycle after acceptance until done.
REQ-011 done  output  1  one-cycle pulse when a press/release sequence completes.
REQ-012 err  output  1  one-cycle pulse when start carries an invalid key.

Function
REQ-013 Keymap: row 0 with columns 011/101/110 gives keys 1/2/3; row 1 gives 4/5/6; row 2 gives 7/8/9; row 3 with column 101 gives key 0.
REQ-014 column shall be combinational from sel, the latched key and the state.
  - In PRESS: column = the key's column pattern when sel equals the key's row; 3'b111 otherwise.
  - In all other states, and for sel 4-7: column = 3'b111.
REQ-015 Frame boundary (frame_tick) shall be detected when the registered previous sel equals 5 and the current sel equals 0.
REQ-016 States: IDLE, ALIGN, PRESS, RELEASE, DONE.
REQ-017 IDLE, start=1 with key <= 9:
  - Latch key, max(hold_scans,1) and gap_scans.
  - Go to ALIGN; busy=1 from the next cycle.
REQ-018 IDLE, start=1 with key > 9: pulse err for one cycle, remain in IDLE, busy stays 0.
REQ-019 ALIGN: on frame_tick, go to PRESS and load the frame counter with the latched hold value.
REQ-020 PRESS: decrement the counter on each frame_tick.
  - On the frame_tick that brings the count to 0, go to RELEASE and load the counter with gap.
  - If gap = 0, go directly to DONE instead.
REQ-021 RELEASE: decrement on each frame_tick; on reaching 0, go to DONE.
REQ-022 DONE: lasts exactly one cycle; done=1 and busy=0 in that cycle; next state is IDLE.
REQ-023 start while busy or in DONE shall be ignored: no latch, no err.
REQ-024 Latched key and counts are unaffected by changes on key, hold_scans or gap_scans after acceptance.
REQ-025 Counter arithmetic shall be unsigned CNT_W bits with no wrap below 0.
REQ-026 A PRESS lasting N frames shall present the key row exactly N times.
REQ-027 sel values 6-7 shall never produce frame_tick and shall force column = 3'b111.

Reset
REQ-028 Reset shall asynchronously force:
  - state = IDLE, counter = 0, latched key = 4'hF, previous sel = 0;
  - column = 3'b111, busy = 0, done = 0, err = 0.
REQ-029 Reset asserted mid-sequence shall abort with no done pulse; column returns to 3'b111 in the same cycle.
REQ-030 After reset is released, the first start shall be accepted normally.

Verification
REQ-031 key=5, hold=2, gap=1, with sel cycling 0-5 -> after one alignment frame:
  - column=101 only while sel=1, for 2 frames;
  - then 1 frame of 111;
  - done pulses once at the end, busy low afterwards.
REQ-032 key=0, hold=0 -> column=101 only while sel=3, for exactly 1 frame; with gap=0, done in the cycle after that frame ends.
REQ-033 key=4'hB -> err=1 for one cycle, busy stays 0, column stays 111.
REQ-034 Second start during PRESS with key=9 -> ignored; the original key continues; exactly one done pulse.
REQ-035 Reset asserted during PRESS -> column=111 immediately, busy=0, no done; a new start with key=7 then shows column=011 on sel=2.
REQ-036 Closed loop with the scanner, debounce and key buffer, hold=3, gap=2, keys 1,2,3 in sequence -> the buffer's low 12 bits read 0x123.
